// File: rtl/high_page_responder_pkg.sv
// Shared definitions for the 0xFF00-0xFFFF high-page responder: state encoding,
// page/region constants, target decode and the latched request payload.
package high_page_responder_pkg;

    localparam int unsigned ADDR_W    = 16;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned HRAM_AW   = 7;
    localparam int unsigned HRAM_DEPTH = 128;

    localparam logic [7:0] HIGH_PAGE = 8'hFF;
    localparam logic [7:0] HRAM_BASE = 8'h80;
    localparam logic [7:0] IE_ADDR   = 8'hFF;
    localparam logic [7:0] OPEN_BUS  = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOCAL   = 2'd1,
        ST_IO_WAIT = 2'd2,
        ST_RESP    = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        TGT_IO   = 2'd0,
        TGT_HRAM = 2'd1,
        TGT_IE   = 2'd2
    } target_e;

    typedef struct packed {
        logic                 write;
        target_e              tgt;
        logic [HRAM_AW-1:0]   offset;
        logic [DATA_W-1:0]    wdata;
    } req_t;

    // Low address byte -> target; 0xFF is IE, the rest of the upper half is HRAM.
    function automatic target_e decode_target(input logic [7:0] lo);
        target_e t;
        if (lo == IE_ADDR) begin
            t = TGT_IE;
        end else if (lo >= HRAM_BASE) begin
            t = TGT_HRAM;
        end else begin
            t = TGT_IO;
        end
        return t;
    endfunction

endpackage

// File: rtl/high_page_responder_hram.sv
// 128x8 high RAM: one synchronous write port and one registered read port.
// Contents are deliberately not reset.
module high_page_responder_hram
    import high_page_responder_pkg::*;
(
    input  logic                clk,
    input  logic                we,
    input  logic [HRAM_AW-1:0]  waddr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic                re,
    input  logic [HRAM_AW-1:0]  raddr,
    output logic [DATA_W-1:0]   rdata
);

    logic [DATA_W-1:0] mem_q [HRAM_DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/high_page_responder.sv
// High-page bus responder: decodes 0xFFxx requests into HRAM, IE or a forwarded
// I/O port with timeout, and returns a one-cycle acknowledge with read data.
module high_page_responder
    import high_page_responder_pkg::*;
#(
    parameter int unsigned IO_TIMEOUT = 8,
    parameter logic [7:0]  IE_RESET   = 8'h00
) (
    input  logic                i_Clk,
    input  logic                i_Reset_n,
    input  logic                i_Req,
    input  logic                i_Write,
    input  logic [ADDR_W-1:0]   i_Address,
    input  logic [DATA_W-1:0]   i_Data,
    output logic [DATA_W-1:0]   o_Data,
    output logic                o_Ack,
    output logic                o_Busy,
    output logic                o_IO_Req,
    output logic                o_IO_Write,
    output logic [HRAM_AW-1:0]  o_IO_Addr,
    output logic [DATA_W-1:0]   o_IO_Data,
    input  logic                i_IO_Ack,
    input  logic [DATA_W-1:0]   i_IO_Data,
    output logic [DATA_W-1:0]   o_IE
);

    localparam int unsigned CNT_W = (IO_TIMEOUT < 2) ? 1 : $clog2(IO_TIMEOUT + 1);

    state_e              state_q, state_d;
    req_t                req_q, req_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                ack_q, ack_d;
    logic                busy_q, busy_d;
    logic                io_req_q, io_req_d;
    logic                io_write_q, io_write_d;
    logic [HRAM_AW-1:0]  io_addr_q, io_addr_d;
    logic [DATA_W-1:0]   io_data_q, io_data_d;
    logic [DATA_W-1:0]   ie_q, ie_d;

    logic                accept;
    target_e             req_tgt;
    logic [CNT_W-1:0]    cnt_next;
    logic                hram_we;
    logic                hram_re;
    logic [DATA_W-1:0]   hram_rdata;

    assign req_tgt  = decode_target(i_Address[7:0]);
    assign accept   = (state_q == ST_IDLE) && i_Req && (i_Address[15:8] == HIGH_PAGE);
    assign cnt_next = cnt_q + CNT_W'(1);

    // HRAM read is launched at acceptance so its data is ready during LOCAL.
    high_page_responder_hram u_hram (
        .clk   (i_Clk),
        .we    (hram_we),
        .waddr (req_q.offset),
        .wdata (req_q.wdata),
        .re    (hram_re),
        .raddr (i_Address[HRAM_AW-1:0]),
        .rdata (hram_rdata)
    );

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        cnt_d      = cnt_q;
        data_d     = '0;
        ack_d      = 1'b0;
        busy_d     = busy_q;
        io_req_d   = io_req_q;
        io_write_d = io_write_q;
        io_addr_d  = io_addr_q;
        io_data_d  = io_data_q;
        ie_d       = ie_q;
        hram_we    = 1'b0;
        hram_re    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    req_d  = '{write: i_Write, tgt: req_tgt,
                               offset: i_Address[HRAM_AW-1:0], wdata: i_Data};
                    busy_d = 1'b1;
                    cnt_d  = '0;
                    if (req_tgt == TGT_IO) begin
                        state_d    = ST_IO_WAIT;
                        io_req_d   = 1'b1;
                        io_write_d = i_Write;
                        io_addr_d  = i_Address[HRAM_AW-1:0];
                        io_data_d  = i_Data;
                    end else begin
                        state_d = ST_LOCAL;
                        hram_re = !i_Write && (req_tgt == TGT_HRAM);
                    end
                end
            end
            ST_LOCAL: begin
                state_d = ST_RESP;
                ack_d   = 1'b1;
                if (req_q.write) begin
                    if (req_q.tgt == TGT_HRAM) begin
                        hram_we = 1'b1;
                    end else begin
                        ie_d = req_q.wdata;
                    end
                end else begin
                    data_d = (req_q.tgt == TGT_IE) ? ie_q : hram_rdata;
                end
            end
            ST_IO_WAIT: begin
                // An ack in the timeout cycle still wins and its data is used.
                if (i_IO_Ack) begin
                    state_d  = ST_RESP;
                    ack_d    = 1'b1;
                    io_req_d = 1'b0;
                    cnt_d    = '0;
                    data_d   = req_q.write ? '0 : i_IO_Data;
                end else if (cnt_next == CNT_W'(IO_TIMEOUT)) begin
                    state_d  = ST_RESP;
                    ack_d    = 1'b1;
                    io_req_d = 1'b0;
                    cnt_d    = '0;
                    data_d   = req_q.write ? '0 : OPEN_BUS;
                end else begin
                    cnt_d = cnt_next;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q    <= ST_IDLE;
            req_q      <= '0;
            cnt_q      <= '0;
            data_q     <= '0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            io_req_q   <= 1'b0;
            io_write_q <= 1'b0;
            io_addr_q  <= '0;
            io_data_q  <= '0;
            ie_q       <= IE_RESET;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            io_req_q   <= io_req_d;
            io_write_q <= io_write_d;
            io_addr_q  <= io_addr_d;
            io_data_q  <= io_data_d;
            ie_q       <= ie_d;
        end
    end

    assign o_Data     = data_q;
    assign o_Ack      = ack_q;
    assign o_Busy     = busy_q;
    assign o_IO_Req   = io_req_q;
    assign o_IO_Write = io_write_q;
    assign o_IO_Addr  = io_addr_q;
    assign o_IO_Data  = io_data_q;
    assign o_IE       = ie_q;

endmodule

// File: tb/tb_high_page_responder.sv
// Self-checking bench for high_page_responder: vector table driven through a
// scoreboard, plus hand-written sequences for ignore and mid-access reset.
module tb_high_page_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [15:0] addr = '0;
    logic [7:0]  wdata = '0;
    logic [7:0]  o_data;
    logic        o_ack;
    logic        o_busy;
    logic        o_io_req;
    logic        o_io_write;
    logic [6:0]  o_io_addr;
    logic [7:0]  o_io_data;
    logic        io_ack = 1'b0;
    logic [7:0]  io_rdata_drv = '0;
    logic [7:0]  o_ie;

    high_page_responder #(.IO_TIMEOUT(8), .IE_RESET(8'h00)) dut (
        .i_Clk      (clk),
        .i_Reset_n  (rst_n),
        .i_Req      (req),
        .i_Write    (wr),
        .i_Address  (addr),
        .i_Data     (wdata),
        .o_Data     (o_data),
        .o_Ack      (o_ack),
        .o_Busy     (o_busy),
        .o_IO_Req   (o_io_req),
        .o_IO_Write (o_io_write),
        .o_IO_Addr  (o_io_addr),
        .o_IO_Data  (o_io_data),
        .i_IO_Ack   (io_ack),
        .i_IO_Data  (io_rdata_drv),
        .o_IE       (o_ie)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic        w;
        logic [15:0] a;
        logic [7:0]  d;
        int          io_lat;
        logic [7:0]  io_rd;
        logic [7:0]  exp_d;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        int         lat;
        int         req_cyc;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    int         n_assert = 0;
    int         n_fail = 0;
    int         io_cycles = 0;
    int         io_lat = 0;
    logic [7:0] io_rd = '0;
    logic       exp_io_w = 1'b0;
    logic [6:0] exp_io_a = '0;
    logic [7:0] exp_io_d = '0;
    vec_t       vt [14];

    // I/O peripheral model: acks in the io_lat-th cycle of o_IO_Req (0 = never).
    int io_cnt = 0;
    always @(negedge clk) begin
        if (!rst_n || !o_io_req) begin
            io_ack = 1'b0;
            io_cnt = 0;
        end else begin
            io_cnt++;
            if (io_lat != 0 && io_cnt == io_lat) begin
                io_ack       = 1'b1;
                io_rdata_drv = io_rd;
            end else begin
                io_ack = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (rst_n) begin
            if (o_io_req) begin
                io_cycles++;
                check("io_addr_stable", 32'(o_io_addr), 32'(exp_io_a));
                check("io_write_stable", 32'(o_io_write), 32'(exp_io_w));
                if (exp_io_w) check("io_wdata_stable", 32'(o_io_data), 32'(exp_io_d));
            end
            if (o_ack) begin
                if (sb.size() == 0) begin
                    check("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("ack_data", 32'(o_data), 32'(e.d));
                    check("ack_latency", 32'(cyc - e.req_cyc), 32'(e.lat));
                    check("io_req_low_in_resp", 32'(o_io_req), 32'd0);
                end
            end else begin
                check("data_zero_without_ack", 32'(o_data), 32'd0);
            end
        end
    endtask

    task automatic issue(input logic w, input logic [15:0] a, input logic [7:0] d,
                         input bit push, input logic [7:0] exp_d, input int exp_lat);
        req   = 1'b1;
        wr    = w;
        addr  = a;
        wdata = d;
        if (push) sb.push_back('{d: exp_d, lat: exp_lat, req_cyc: cyc});
        tick();
        req   = 1'b0;
        wr    = 1'b0;
        wdata = '0;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 40 && sb.size() != 0; k++) tick();
        if (sb.size() != 0) begin
            check("ack_wait_expired", 32'd0, 32'd1);
            sb.delete();
        end
        tick();
    endtask

    task automatic run(input vec_t v);
        int start;
        int exp_cyc;
        io_lat   = v.io_lat;
        io_rd    = v.io_rd;
        exp_io_w = v.w;
        exp_io_a = v.a[6:0];
        exp_io_d = v.d;
        start    = io_cycles;
        issue(v.w, v.a, v.d, 1'b1, v.exp_d, v.exp_lat);
        wait_done();
        exp_cyc = (v.a[7] == 1'b0) ? ((v.io_lat >= 1 && v.io_lat <= 8) ? v.io_lat : 8) : 0;
        check("io_req_cycles", 32'(io_cycles - start), 32'(exp_cyc));
    endtask

    initial begin
        vt[0]  = '{w: 1'b0, a: 16'hFFFF, d: 8'h00, io_lat: 0, io_rd: 8'h00, exp_d: 8'h00, exp_lat: 2};
        vt[1]  = '{w: 1'b1, a: 16'hFF80, d: 8'hA5, io_lat: 0, io_rd: 8'h00, exp_d: 8'h00, exp_lat: 2};
        vt[2]  = '{w: 1'b0, a: 16'hFF80, d: 8'h00, io_lat: 0, io_rd: 8'h00, exp_d: 8'hA5, exp_lat: 2};
        vt[3]  = '{w: 1'b1, a: 16'hFFFE, d: 8'h3C, io_lat: 0, io_rd: 8'h00, exp_d: 8'h00, exp_lat: 2};
        vt[4]  = '{w: 1'b0, a: 16'hFFFE, d: 8'h00, io_lat: 0, io_rd: 8'h00, exp_d: 8'h3C, exp_lat: 2};
        vt[5]  = '{w: 1'b1, a: 16'hFFFF, d: 8'h1F, io_lat: 0, io_rd: 8'h00, exp_d: 8'h00, exp_lat: 2};
        vt[6]  = '{w: 1'b0, a: 16'hFFFF, d: 8'h00, io_lat: 0, io_rd: 8'h00, exp_d: 8'h1F, exp_lat: 2};
        vt[7]  = '{w: 1'b0, a: 16'hFF44, d: 8'h00, io_lat: 3, io_rd: 8'h90, exp_d: 8'h90, exp_lat: 4};
        vt[8]  = '{w: 1'b0, a: 16'hFF10, d: 8'h00, io_lat: 0, io_rd: 8'h00, exp_d: 8'hFF, exp_lat: 9};
        vt[9]  = '{w: 1'b1, a: 16'hFF01, d: 8'h6B, io_lat: 1, io_rd: 8'h00, exp_d: 8'h00, exp_lat: 2};
        vt[10] = '{w: 1'b0, a: 16'hFF7F, d: 8'h00, io_lat: 2, io_rd: 8'h3E, exp_d: 8'h3E, exp_lat: 3};
        vt[11] = '{w: 1'b0, a: 16'hFF20, d: 8'h00, io_lat: 8, io_rd: 8'h77, exp_d: 8'h77, exp_lat: 9};
        vt[12] = '{w: 1'b1, a: 16'hFF30, d: 8'hC4, io_lat: 0, io_rd: 8'h00, exp_d: 8'h00, exp_lat: 9};
        vt[13] = '{w: 1'b1, a: 16'hFF81, d: 8'h55, io_lat: 0, io_rd: 8'h00, exp_d: 8'h00, exp_lat: 2};

        repeat (3) @(negedge clk);
        check("rst_data", 32'(o_data), 32'd0);
        check("rst_ack", 32'(o_ack), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_io_req", 32'(o_io_req), 32'd0);
        check("rst_io_write", 32'(o_io_write), 32'd0);
        check("rst_io_addr", 32'(o_io_addr), 32'd0);
        check("rst_io_data", 32'(o_io_data), 32'd0);
        check("rst_ie", 32'(o_ie), 32'h00);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 14; i++) run(vt[i]);
        check("ie_after_write", 32'(o_ie), 32'h1F);

        // Out-of-page request, then a request while busy: neither may land.
        io_lat = 0;
        issue(1'b1, 16'hC000, 8'h12, 1'b0, 8'h00, 0);
        tick();
        check("out_of_page_not_busy", 32'(o_busy), 32'd0);
        issue(1'b0, 16'hFF80, 8'h00, 1'b1, 8'hA5, 2);
        check("busy_during_access", 32'(o_busy), 32'd1);
        issue(1'b1, 16'hFF81, 8'h99, 1'b0, 8'h00, 0);
        wait_done();
        run('{w: 1'b0, a: 16'hFF81, d: 8'h00, io_lat: 0, io_rd: 8'h00, exp_d: 8'h55, exp_lat: 2});

        // Reset while waiting on the I/O port aborts the access silently.
        io_lat   = 0;
        exp_io_w = 1'b0;
        exp_io_a = 7'h10;
        issue(1'b0, 16'hFF10, 8'h00, 1'b1, 8'hFF, 9);
        tick();
        tick();
        check("io_req_before_reset", 32'(o_io_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("reset_drops_io_req", 32'(o_io_req), 32'd0);
        check("reset_drops_busy", 32'(o_busy), 32'd0);
        check("reset_no_ack", 32'(o_ack), 32'd0);
        check("reset_restores_ie", 32'(o_ie), 32'h00);
        sb.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        run('{w: 1'b0, a: 16'hFF80, d: 8'h00, io_lat: 0, io_rd: 8'h00, exp_d: 8'hA5, exp_lat: 2});
        run('{w: 1'b0, a: 16'hFF44, d: 8'h00, io_lat: 3, io_rd: 8'h5A, exp_d: 8'h5A, exp_lat: 4});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/high_page_responder.md
Name: high_page_responder

Overview:
- Bus responder for the 0xFF00–0xFFFF high page targeted by the CPU's LDH-class accesses ((a8) and (C) forms).
- Sits between the CPU address/data bus and three targets: 127-byte HRAM, the IE register, and a forwarded I/O peripheral port.
- Accepts one-cycle requests and returns an acknowledge, with read data on reads.
- Out-of-page addresses are ignored, so other responders can share the bus.

Parameters:
- IO_TIMEOUT, 8, clock cycles to wait for i_IO_Ack before an I/O access is abandoned.
- IE_RESET, 8'h00, reset value of the IE register.

Ports:
- i_Clk  input  1  system clock; all state updates on the rising edge.
- i_Reset_n  input  1  asynchronous, active-low reset.
- i_Req  input  1  one-cycle request strobe from the CPU bus stage.
- i_Write  input  1  1 = write, 0 = read; sampled with i_Req.
- i_Address  input  16  request address; sampled with i_Req.
- i_Data  input  8  CPU write data; sampled with i_Req.
- o_Data  output  8  read data; valid only while o_Ack=1 and the request was a read.
- o_Ack  output  1  one-cycle completion pulse.
- o_Busy  output  1  high from the cycle after an accepted request until the o_Ack cycle, inclusive.
- o_IO_Req  output  1  level request to the I/O fabric; held until ack or timeout.
- o_IO_Write  output  1  I/O direction; stable while o_IO_Req=1.
- o_IO_Addr  output  7  I/O offset (address[6:0] within 0xFF00–0xFF7F).
- o_IO_Data  output  8  I/O write data.
- i_IO_Ack  input  1  I/O completion; sampled only while o_IO_Req=1.
- i_IO_Data  input  8  I/O read data; valid with i_IO_Ack.
- o_IE  output  8  current IE register contents, for the interrupt controller.

Behaviour:
- Reset is asynchronous, active-low, single clock domain.
  - o_Data=8'h00, o_Ack=0, o_Busy=0, o_IO_Req=0, o_IO_Write=0, o_IO_Addr=0, o_IO_Data=0, o_IE=IE_RESET.
  - State returns to IDLE and the timeout counter clears.
  - HRAM contents are not reset (undefined after power-up).
- Reset mid-operation aborts the access with no o_Ack. Any pending o_IO_Req drops immediately.
- Acceptance: a request is accepted only in IDLE with i_Req=1 and i_Address[15:8]=8'hFF. In all other cases it is ignored: no o_Ack, no state change.
- i_Req while o_Busy=1 is ignored and not queued. The CPU must not issue one.
- States:
  - IDLE: wait for an accepted request.
  - LOCAL: one cycle for HRAM or IE.
  - IO_WAIT: o_IO_Req held.
  - RESP: o_Ack=1 for one cycle, then back to IDLE.
- Decode of address[7:0]:
  - 0x00–0x7F goes to IO_WAIT.
  - 0x80–0xFE goes to HRAM at index address[6:0]-0 (entry 0x7F unused).
  - 0xFF goes to IE.
- HRAM/IE write: storage updates on the edge leaving LOCAL. o_Ack occurs 2 cycles after i_Req.
- HRAM/IE read: data is registered in LOCAL and presented with o_Ack at RESP. Latency is 2 cycles from i_Req to o_Ack.
- Read-after-write to the same HRAM byte on back-to-back requests returns the new value.
- o_IE updates the cycle after the write's LOCAL cycle.
- IO_WAIT:
  - o_IO_Req, o_IO_Write, o_IO_Addr and o_IO_Data are registered on entry and stay stable until exit.
  - i_IO_Ack=1 captures i_IO_Data on a read, then goes to RESP.
  - i_IO_Ack in the same cycle o_IO_Req is first asserted is legal.
  - The timeout counter increments each IO_WAIT cycle.
  - When the count reaches IO_TIMEOUT without ack: drop o_IO_Req, go to RESP with o_Data=8'hFF on a read (open-bus value). A write is simply acked.
  - i_IO_Ack arriving in the same cycle the timeout is reached takes priority: the data is used.
  - i_IO_Ack outside IO_WAIT is ignored.
- o_Data is 8'h00 whenever o_Ack=0, and also during write acks.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, LOCAL, IO_WAIT, RESP);
  - page constant 8'hFF;
  - region boundaries 8'h80 and 8'hFF;
  - open-bus value 8'hFF.
- One sub-module is natural: hram_128x8, a synchronous 128x8 register array with one write and one registered read port. The responder keeps the FSM, decode, IE, timeout counter and I/O handshake.

Test Plan:
- Write 0xA5 to 0xFF80, then read 0xFF80 -> each o_Ack arrives 2 cycles after i_Req; the read returns o_Data=0xA5. A read of 0xFFFE after a write of 0x3C returns 0x3C.
- After reset, read 0xFFFF -> o_Data=IE_RESET, o_IE=IE_RESET. Write 0x1F to 0xFFFF -> o_IE=0x1F; a read-back returns 0x1F.
- Read 0xFF44 with the I/O model acking after 3 cycles with 0x90:
  - o_IO_Req=1, o_IO_Addr=0x44, o_IO_Write=0, held stable for 3 cycles;
  - then o_Ack=1 with o_Data=0x90, and o_IO_Req=0 in the RESP cycle.
- Read 0xFF10 with no I/O ack -> o_IO_Req drops after IO_TIMEOUT=8 cycles; o_Ack=1 with o_Data=0xFF. Then a write to 0xFF01 acked in the same cycle as o_IO_Req -> o_Ack 2 cycles after i_Req.
- i_Req to 0xC000, and a second i_Req to 0xFF81 while o_Busy=1 -> no o_Ack for either, and HRAM is unchanged (verified by read-back).
- Assert i_Reset_n=0 while in IO_WAIT -> o_IO_Req=0 and o_Busy=0 immediately with no o_Ack. o_IE returns to IE_RESET. A new request after release completes normally.
